// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// The master drives operands and observes the product; the slave is the multiplier.
interface booth_multiplier_if #(
  parameter int WORD_LENGTH = 16
);
  logic [WORD_LENGTH-1:0] Multiplicand;
  logic [WORD_LENGTH-1:0] Multiplier;
  logic [WORD_LENGTH-1:0] Result;
  logic                   Ready;
  logic                   Overflow;

  modport master (
    output Multiplicand,
    output Multiplier,
    input  Result,
    input  Ready,
    input  Overflow
  );

  modport slave (
    input  Multiplicand,
    input  Multiplier,
    output Result,
    output Ready,
    output Overflow
  );
endinterface

// File: rtl/booth_multiplier.sv
// Free-running radix-2 Booth multiplier for signed WORD_LENGTH-bit operands.
// Each pass takes LOAD (1 cycle) + CALC (WORD_LENGTH cycles) + DONE (1 cycle);
// Result/Overflow are published in DONE and qualified by a one-cycle Ready pulse.
module booth_multiplier #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  booth_multiplier_if.slave   bus
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  // Accumulator is one bit wider than the operands so that subtracting the
  // most negative multiplicand cannot wrap.
  logic [W:0]      a_reg, a_next;
  logic [W:0]      m_reg, m_next;
  logic [W-1:0]    q_reg, q_next;
  logic            qm1_reg, qm1_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [W-1:0]    result_reg, result_next;
  logic            overflow_reg, overflow_next;
  logic            ready_reg, ready_next;

  logic [W:0]      sum;
  logic [2*W-1:0]  prod;
  logic [W:0]      prod_hi;

  // State and datapath registers; reset clears everything and restarts at LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LOAD;
      a_reg        <= '0;
      m_reg        <= '0;
      q_reg        <= '0;
      qm1_reg      <= 1'b0;
      count_reg    <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      m_reg        <= m_next;
      q_reg        <= q_next;
      qm1_reg      <= qm1_next;
      count_reg    <= count_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      ready_reg    <= ready_next;
    end
  end

  // Next-state and datapath logic: operand capture, Booth add/sub + shift, publish.
  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    m_next        = m_reg;
    q_next        = q_reg;
    qm1_next      = qm1_reg;
    count_next    = count_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    ready_next    = 1'b0;
    sum           = a_reg;
    prod          = {a_reg[W-1:0], q_reg};
    prod_hi       = prod[2*W-1:W-1];

    unique case (state_reg)
      LOAD: begin
        a_next     = '0;
        m_next     = {bus.Multiplicand[W-1], bus.Multiplicand};
        q_next     = bus.Multiplier;
        qm1_next   = 1'b0;
        count_next = '0;
        state_next = CALC;
      end
      CALC: begin
        unique case ({q_reg[0], qm1_reg})
          2'b01:   sum = a_reg + m_reg;
          2'b10:   sum = a_reg - m_reg;
          default: sum = a_reg;
        endcase
        // Arithmetic right shift of {A, Q, Q_-1}.
        a_next     = {sum[W], sum[W:1]};
        q_next     = {sum[0], q_reg[W-1:1]};
        qm1_next   = q_reg[0];
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(W - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        result_next   = q_reg;
        // Product fits in W signed bits only if its top W+1 bits are all equal.
        overflow_next = !((&prod_hi) || !(|prod_hi));
        ready_next    = 1'b1;
        state_next    = LOAD;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  assign bus.Result   = result_reg;
  assign bus.Overflow = overflow_reg;
  assign bus.Ready    = ready_reg;
endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: reset behaviour, latency, directed
// corner products, randomized back-to-back products, operand isolation and
// reset during CALC/DONE, all against a plain signed-arithmetic reference.
module tb_booth_multiplier;
  localparam int W = 16;
  localparam int PERIOD = W + 2;
  localparam int TIMEOUT = 60;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  booth_multiplier_if #(.WORD_LENGTH(W)) bus ();

  booth_multiplier #(.WORD_LENGTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: exact signed product, truncated result and range check.
  function automatic longint ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
    longint a;
    longint b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return a * b;
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] m, input logic [W-1:0] q);
    longint p;
    p = ref_prod(m, q);
    return p[W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] m, input logic [W-1:0] q);
    longint p;
    longint hi;
    longint lo;
    p  = ref_prod(m, q);
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    return (p > hi) || (p < lo);
  endfunction

  // Counts falling edges until Ready is seen, bounded by TIMEOUT.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.Ready && n < TIMEOUT);
  endtask

  task automatic check_result(input string name, input int n,
                              input logic [W-1:0] m, input logic [W-1:0] q);
    logic [W-1:0] exp_r;
    logic         exp_o;
    exp_r = ref_result(m, q);
    exp_o = ref_ovf(m, q);
    $display("%s: M=%h Q=%h Result=%h Overflow=%b cycles=%0d", name, m, q,
             bus.Result, bus.Overflow, n);
    checks++;
    if (n !== PERIOD) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, PERIOD);
    end
    checks++;
    if (bus.Result !== exp_r) begin
      fails++;
      $display("FAIL %s result: got %h, expected %h", name, bus.Result, exp_r);
    end
    checks++;
    if (bus.Overflow !== exp_o) begin
      fails++;
      $display("FAIL %s overflow: got %b, expected %b", name, bus.Overflow, exp_o);
    end
  endtask

  // Called at a falling edge where Ready is high (state is LOAD): apply operands,
  // wait for the next Ready and check the product and that outputs held meanwhile.
  task automatic do_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q);
    logic [W-1:0] prev_r;
    logic         prev_o;
    logic         stable;
    int           n;
    bus.Multiplicand = m;
    bus.Multiplier   = q;
    prev_r = bus.Result;
    prev_o = bus.Overflow;
    stable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.Ready && (bus.Result !== prev_r || bus.Overflow !== prev_o)) stable = 1'b0;
    end while (!bus.Ready && n < TIMEOUT);
    check_result(name, n, m, q);
    checks++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL %s hold: outputs changed between Ready pulses, expected stable", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) begin
      bus.Multiplicand = W'($urandom);
      bus.Multiplier   = W'($urandom);
      @(negedge clk);
      checks++;
      if (bus.Result !== '0 || bus.Ready !== 1'b0 || bus.Overflow !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: got Result=%h Ready=%b Overflow=%b, expected all 0",
                 bus.Result, bus.Ready, bus.Overflow);
      end
    end
    $display("test_reset: 10 cycles held");
  endtask

  task automatic test_first_latency();
    int n;
    bus.Multiplicand = 16'h8008;
    bus.Multiplier   = 16'h0002;
    reset = 1'b0;
    wait_ready(n);
    check_result("first_latency", n, 16'h8008, 16'h0002);
    checks++;
    if (bus.Result !== 16'h0010 || bus.Overflow !== 1'b1) begin
      fails++;
      $display("FAIL first_const: got %h/%b, expected 0010/1", bus.Result, bus.Overflow);
    end
  endtask

  task automatic test_directed();
    do_op("neg_times_pos", 16'd3, 16'hFFFC);
    checks++;
    if (bus.Result !== 16'hFFF4) begin
      fails++;
      $display("FAIL neg_const: got %h, expected fff4", bus.Result);
    end
    do_op("small", 16'd7, 16'd6);
    checks++;
    if (bus.Result !== 16'd42) begin
      fails++;
      $display("FAIL small_const: got %0d, expected 42", bus.Result);
    end
    do_op("min_times_min", 16'h8000, 16'h8000);
    checks++;
    if (bus.Result !== 16'h0000 || bus.Overflow !== 1'b1) begin
      fails++;
      $display("FAIL minmin_const: got %h/%b, expected 0000/1", bus.Result, bus.Overflow);
    end
    do_op("min_times_one", 16'h8000, 16'h0001);
    do_op("zero", 16'h0000, 16'd12345);
    do_op("max_times_max", 16'h7FFF, 16'h7FFF);
    do_op("min_times_neg1", 16'h8000, 16'hFFFF);
    do_op("neg1_times_neg1", 16'hFFFF, 16'hFFFF);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] m;
    logic [W-1:0] q;
    for (int i = 0; i < 30; i++) begin
      m = W'($urandom);
      q = W'($urandom);
      // Bias some operands toward small magnitudes to exercise non-overflow cases.
      if (i % 3 == 0) m = W'($signed(8'($urandom)));
      if (i % 4 == 0) q = W'($signed(8'($urandom)));
      do_op("random", m, q);
    end
  endtask

  task automatic test_operand_change();
    logic [W-1:0] m;
    logic [W-1:0] q;
    int n;
    m = W'($urandom);
    q = W'($urandom);
    bus.Multiplicand = m;
    bus.Multiplier   = q;
    @(negedge clk);
    n = 1;
    bus.Multiplicand = W'($urandom);
    bus.Multiplier   = ~q;
    while (!bus.Ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_result("operand_change", n, m, q);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] m;
    logic [W-1:0] q;
    int n;
    // Reset in the middle of CALC.
    bus.Multiplicand = W'($urandom);
    bus.Multiplier   = W'($urandom);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Result !== '0 || bus.Ready !== 1'b0 || bus.Overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_calc: got Result=%h Ready=%b Overflow=%b, expected all 0",
               bus.Result, bus.Ready, bus.Overflow);
    end
    m = 16'h8008;
    q = 16'h0002;
    bus.Multiplicand = m;
    bus.Multiplier   = q;
    reset = 1'b0;
    wait_ready(n);
    check_result("after_reset_calc", n, m, q);

    // Reset coinciding with DONE: Ready must not pulse.
    bus.Multiplicand = 16'd7;
    bus.Multiplier   = 16'd6;
    repeat (PERIOD - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Ready !== 1'b0 || bus.Result !== '0 || bus.Overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_done: got Result=%h Ready=%b Overflow=%b, expected all 0",
               bus.Result, bus.Ready, bus.Overflow);
    end
    m = W'($urandom);
    q = W'($urandom);
    bus.Multiplicand = m;
    bus.Multiplier   = q;
    reset = 1'b0;
    wait_ready(n);
    check_result("after_reset_done", n, m, q);
  endtask

  initial begin
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    reset = 1'b1;
    test_reset();
    test_first_latency();
    test_directed();
    test_back_to_back();
    test_operand_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
